mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Accepts one request at a time, launches it on the downstream memory port, waits for the variable-latency response and returns it to the owner. Generates the byte write/read mask from the LSU access size. It is the only master on the memory port.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction fetch unit
// (read-only, 32-bit fetches) and the load/store unit. One transaction is in
// flight at a time. Ties between the two requesters are broken round-robin.
module mem_port_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [3:0]        lsu_type,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_mask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   localparam logic       OWN_IFU  = 1'b0;
   localparam logic       OWN_LSU  = 1'b1;
   localparam logic [7:0] IFU_MASK = 8'h0F;

   // Byte mask from an access size in bytes; any size of 8 or more covers all lanes.
   function automatic logic [7:0] size_to_mask(input logic [3:0] size);
      logic [7:0] shifted;
      shifted = 8'hFF << size;
      return ~shifted;
   endfunction

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                prio_q, prio_d;
   logic                mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_wen_q, mem_wen_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [7:0]          mem_mask_q, mem_mask_d;
   logic                ifu_resp_valid_q, ifu_resp_valid_d;
   logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
   logic                lsu_resp_valid_q, lsu_resp_valid_d;
   logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

   logic                idle_s;
   logic                sel_lsu_s;
   logic                sel_ifu_s;
   logic                ifu_accept_s;
   logic                lsu_accept_s;

   // Requester selection: only one side ever sees ready, and never during reset.
   always_comb begin
      idle_s        = (state_q == ST_IDLE) && reset;
      sel_lsu_s     = lsu_req_valid && (!ifu_req_valid || (prio_q == OWN_LSU));
      sel_ifu_s     = ifu_req_valid && !sel_lsu_s;
      ifu_req_ready = idle_s && sel_ifu_s;
      lsu_req_ready = idle_s && sel_lsu_s;
      ifu_accept_s  = ifu_req_valid && ifu_req_ready;
      lsu_accept_s  = lsu_req_valid && lsu_req_ready;
   end

   // Next-state and next-output computation for the transaction sequencer.
   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      prio_d           = prio_q;
      mem_req_valid_d  = mem_req_valid_q;
      mem_addr_d       = mem_addr_q;
      mem_wen_d        = mem_wen_q;
      mem_wdata_d      = mem_wdata_q;
      mem_mask_d       = mem_mask_q;
      ifu_resp_valid_d = 1'b0;
      ifu_rdata_d      = ifu_rdata_q;
      lsu_resp_valid_d = 1'b0;
      lsu_rdata_d      = lsu_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (lsu_accept_s) begin
               state_d         = ST_REQ;
               owner_d         = OWN_LSU;
               prio_d          = OWN_IFU;
               mem_req_valid_d = 1'b1;
               mem_addr_d      = lsu_addr;
               mem_wen_d       = lsu_wen;
               mem_wdata_d     = lsu_wdata;
               mem_mask_d      = size_to_mask(lsu_type);
            end else if (ifu_accept_s) begin
               state_d         = ST_REQ;
               owner_d         = OWN_IFU;
               prio_d          = OWN_LSU;
               mem_req_valid_d = 1'b1;
               mem_addr_d      = ifu_addr;
               mem_wen_d       = 1'b0;
               mem_wdata_d     = '0;
               mem_mask_d      = IFU_MASK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d         = ST_WAIT;
               mem_req_valid_d = 1'b0;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               state_d = ST_IDLE;
               if (owner_q == OWN_LSU) begin
                  lsu_resp_valid_d = 1'b1;
                  // Stores are acknowledged with zero data.
                  lsu_rdata_d      = mem_wen_q ? '0 : mem_rdata;
               end else begin
                  ifu_resp_valid_d = 1'b1;
                  ifu_rdata_d      = mem_rdata;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d         = ST_IDLE;
            mem_req_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         owner_q          <= OWN_IFU;
         prio_q           <= OWN_LSU;
         mem_req_valid_q  <= 1'b0;
         mem_addr_q       <= '0;
         mem_wen_q        <= 1'b0;
         mem_wdata_q      <= '0;
         mem_mask_q       <= 8'h00;
         ifu_resp_valid_q <= 1'b0;
         ifu_rdata_q      <= '0;
         lsu_resp_valid_q <= 1'b0;
         lsu_rdata_q      <= '0;
      end else begin
         state_q          <= state_d;
         owner_q          <= owner_d;
         prio_q           <= prio_d;
         mem_req_valid_q  <= mem_req_valid_d;
         mem_addr_q       <= mem_addr_d;
         mem_wen_q        <= mem_wen_d;
         mem_wdata_q      <= mem_wdata_d;
         mem_mask_q       <= mem_mask_d;
         ifu_resp_valid_q <= ifu_resp_valid_d;
         ifu_rdata_q      <= ifu_rdata_d;
         lsu_resp_valid_q <= lsu_resp_valid_d;
         lsu_rdata_q      <= lsu_rdata_d;
      end
   end

   assign mem_req_valid  = mem_req_valid_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wen        = mem_wen_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_mask       = mem_mask_q;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign ifu_rdata      = ifu_rdata_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, a transaction-level reference
// model compared against the DUT every cycle, plus hand-computed literal checks.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ifu_req_valid = 1'b0;
   logic        ifu_req_ready;
   logic [63:0] ifu_addr = 64'h0;
   logic        ifu_resp_valid;
   logic [63:0] ifu_rdata;
   logic        lsu_req_valid = 1'b0;
   logic        lsu_req_ready;
   logic [63:0] lsu_addr = 64'h0;
   logic        lsu_wen = 1'b0;
   logic [63:0] lsu_wdata = 64'h0;
   logic [3:0]  lsu_type = 4'd0;
   logic        lsu_resp_valid;
   logic [63:0] lsu_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_mask;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_rdata = 64'h0;

   int checks = 0;
   int errors = 0;
   int n_ifu_pulses = 0;
   int n_lsu_pulses = 0;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clock(clock), .reset(reset),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_type(lsu_type),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // Mask from access size: a run of 'size' ones, saturating at all eight lanes.
   function automatic logic [7:0] mask_of(input logic [3:0] size);
      if (size >= 4'd8) return 8'hFF;
      return (8'd1 << size) - 8'd1;
   endfunction

   bit          m_busy, m_issuing, m_owner, m_prio;   // owner/prio: 1 = LSU
   logic [63:0] m_addr, m_wdata, m_ifu_rdata, m_lsu_rdata;
   logic        m_wen, m_ifu_pulse, m_lsu_pulse, m_g;
   logic [7:0]  m_mask;
   bit          grants[$];

   always @(posedge clock) begin
      if (!reset) begin
         m_busy = 1'b0; m_issuing = 1'b0; m_owner = 1'b0; m_prio = 1'b1;
         m_addr = 64'h0; m_wdata = 64'h0; m_wen = 1'b0; m_mask = 8'h00;
         m_ifu_rdata = 64'h0; m_lsu_rdata = 64'h0;
         m_ifu_pulse = 1'b0; m_lsu_pulse = 1'b0;
         grants.delete();
      end else begin
         m_ifu_pulse = 1'b0;
         m_lsu_pulse = 1'b0;
         if (!m_busy) begin
            if (ifu_req_valid || lsu_req_valid) begin
               m_g = (ifu_req_valid && lsu_req_valid) ? m_prio : lsu_req_valid;
               grants.push_back(m_g);
               m_owner = m_g; m_prio = !m_g; m_busy = 1'b1; m_issuing = 1'b1;
               if (m_g) begin
                  m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_mask = mask_of(lsu_type);
               end else begin
                  m_addr = ifu_addr; m_wen = 1'b0; m_wdata = 64'h0; m_mask = 8'h0F;
               end
            end
         end else if (m_issuing) begin
            if (mem_req_ready) m_issuing = 1'b0;
         end else if (mem_resp_valid) begin
            m_busy = 1'b0;
            if (m_owner) begin
               m_lsu_pulse = 1'b1;
               m_lsu_rdata = m_wen ? 64'h0 : mem_rdata;
            end else begin
               m_ifu_pulse = 1'b1;
               m_ifu_rdata = mem_rdata;
            end
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   logic e_sel, e_any, e_ifu_rdy, e_lsu_rdy;
   always @(negedge clock) begin
      e_any = ifu_req_valid || lsu_req_valid;
      e_sel = (ifu_req_valid && lsu_req_valid) ? m_prio : lsu_req_valid;
      e_ifu_rdy = reset && !m_busy && e_any && !e_sel;
      e_lsu_rdy = reset && !m_busy && e_any && e_sel;
      chk("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
      chk("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
      if (!reset) begin
         chk("rst mem_req_valid", mem_req_valid, 64'h0);
         chk("rst mem_addr", mem_addr, 64'h0);
         chk("rst mem_wen", mem_wen, 64'h0);
         chk("rst mem_wdata", mem_wdata, 64'h0);
         chk("rst mem_mask", mem_mask, 64'h0);
         chk("rst ifu_resp_valid", ifu_resp_valid, 64'h0);
         chk("rst lsu_resp_valid", lsu_resp_valid, 64'h0);
         chk("rst ifu_rdata", ifu_rdata, 64'h0);
         chk("rst lsu_rdata", lsu_rdata, 64'h0);
      end else begin
         chk("mem_req_valid", mem_req_valid, m_issuing);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wen", mem_wen, m_wen);
         chk("mem_wdata", mem_wdata, m_wdata);
         chk("mem_mask", mem_mask, m_mask);
         chk("ifu_resp_valid", ifu_resp_valid, m_ifu_pulse);
         chk("lsu_resp_valid", lsu_resp_valid, m_lsu_pulse);
         chk("ifu_rdata", ifu_rdata, m_ifu_rdata);
         chk("lsu_rdata", lsu_rdata, m_lsu_rdata);
         chk("resp exclusive", ifu_resp_valid && lsu_resp_valid, 64'h0);
         if (ifu_resp_valid === 1'b1) n_ifu_pulses++;
         if (lsu_resp_valid === 1'b1) n_lsu_pulses++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Raise a request and hold it until the DUT accepts it (bounded).
   task automatic request(input logic is_lsu, input logic [63:0] addr, input logic wen,
                          input logic [63:0] wdata, input logic [3:0] size);
      logic done;
      done = 1'b0;
      if (is_lsu) begin
         lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_type = size;
      end else begin
         ifu_req_valid = 1'b1; ifu_addr = addr;
      end
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clock);
         if ((is_lsu ? lsu_req_ready : ifu_req_ready) === 1'b1) done = 1'b1;
         step();
      end
      if (is_lsu) lsu_req_valid = 1'b0;
      else ifu_req_valid = 1'b0;
      chk("request accepted", done, 64'h1);
   endtask

   // Act as memory: stall, handshake, then respond 'lat' cycles after the handshake.
   task automatic serve(input int stall, input int lat, input logic [63:0] data);
      int guard;
      guard = 0;
      while (mem_req_valid !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      chk("mem request seen", mem_req_valid, 64'h1);
      mem_req_ready = 1'b0;
      repeat (stall) step();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      repeat (lat - 1) step();
      mem_resp_valid = 1'b1;
      mem_rdata = data;
      step();
      mem_resp_valid = 1'b0;
   endtask

   logic [63:0] cdata [4];
   bit          exp_order [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      cdata     = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                    64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
      exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

      // Reset with an IFU request already pending: no ready while reset is low.
      #2;
      reset = 1'b0;
      ifu_req_valid = 1'b1;
      ifu_addr = 64'h0000_0000_8000_0000;
      @(negedge clock);
      chk("ready in reset", ifu_req_ready, 64'h0);
      step();
      step();

      // Single IFU fetch, cycle-exact.
      reset = 1'b1;
      @(negedge clock);
      chk("ifu ready first idle cycle", ifu_req_ready, 64'h1);
      step();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clock);
      chk("fetch mem_req_valid", mem_req_valid, 64'h1);
      chk("fetch mem_mask", mem_mask, 64'h0F);
      chk("fetch mem_wen", mem_wen, 64'h0);
      chk("fetch mem_addr", mem_addr, 64'h0000_0000_8000_0000);
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata = 64'h0000_0013_0000_0297;
      @(negedge clock);
      chk("fetch no early pulse", ifu_resp_valid, 64'h0);
      step();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("fetch pulse cycle 3", ifu_resp_valid, 64'h1);
      chk("fetch rdata", ifu_rdata, 64'h0000_0013_0000_0297);
      chk("fetch no lsu pulse", lsu_resp_valid, 64'h0);
      step();

      // LSU halfword store.
      request(1'b1, 64'h0000_0000_8000_1002, 1'b1, 64'hABCD, 4'd2);
      @(negedge clock);
      chk("store mem_mask", mem_mask, 64'h03);
      chk("store mem_wen", mem_wen, 64'h1);
      chk("store mem_wdata", mem_wdata, 64'hABCD);
      step();
      serve(0, 1, 64'hDEAD_BEEF_0000_0001);
      @(negedge clock);
      chk("store ack pulse", lsu_resp_valid, 64'h1);
      chk("store ack rdata", lsu_rdata, 64'h0);
      step();

      // Contention straight after reset: both requesters held valid.
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = 64'h0000_0000_8000_0100;
      lsu_req_valid = 1'b1; lsu_addr = 64'h0000_0000_8000_2000;
      lsu_wen = 1'b0; lsu_type = 4'd4;
      for (int i = 0; i < 4; i++) begin
         serve(0, i + 1, cdata[i]);
         if (i == 3) begin
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
         end
         @(negedge clock);
         if (exp_order[i]) begin
            chk("contention lsu pulse", lsu_resp_valid, 64'h1);
            chk("contention lsu data", lsu_rdata, cdata[i]);
         end else begin
            chk("contention ifu pulse", ifu_resp_valid, 64'h1);
            chk("contention ifu data", ifu_rdata, cdata[i]);
         end
         step();
      end
      chk("grant count", grants.size(), 64'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         chk("grant order", grants[i], exp_order[i]);

      // Backpressure: 3 stall cycles, response 5 cycles after the handshake,
      // with an LSU request held pending the whole time.
      request(1'b0, 64'h0000_0000_8000_0400, 1'b0, 64'h0, 4'd0);
      lsu_req_valid = 1'b1; lsu_addr = 64'h0000_0000_8000_3008;
      lsu_wen = 1'b0; lsu_type = 4'd1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_req_ready = 1'b1;
         @(negedge clock);
         chk("stall mem_req_valid", mem_req_valid, 64'h1);
         chk("stall mem_addr", mem_addr, 64'h0000_0000_8000_0400);
         chk("stall mem_mask", mem_mask, 64'h0F);
         chk("stall lsu_ready", lsu_req_ready, 64'h0);
         chk("stall ifu_ready", ifu_req_ready, 64'h0);
         step();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("wait lsu_ready", lsu_req_ready, 64'h0);
         chk("wait ifu pulse", ifu_resp_valid, 64'h0);
         step();
      end
      mem_resp_valid = 1'b1;
      mem_rdata = 64'h0BAD_F00D_1234_5678;
      @(negedge clock);
      chk("bp no early pulse", ifu_resp_valid, 64'h0);
      step();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("bp pulse", ifu_resp_valid, 64'h1);
      chk("bp rdata", ifu_rdata, 64'h0BAD_F00D_1234_5678);
      chk("held lsu now ready", lsu_req_ready, 64'h1);
      step();
      lsu_req_valid = 1'b0;
      @(negedge clock);
      chk("byte load mask", mem_mask, 64'h01);
      chk("byte load addr", mem_addr, 64'h0000_0000_8000_3008);
      step();
      serve(0, 2, 64'h5555);
      @(negedge clock);
      chk("byte load pulse", lsu_resp_valid, 64'h1);
      step();

      // Spurious response in IDLE is ignored.
      mem_resp_valid = 1'b1;
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("spurious ifu pulse", ifu_resp_valid, 64'h0);
      chk("spurious lsu pulse", lsu_resp_valid, 64'h0);
      chk("spurious lsu_rdata held", lsu_rdata, 64'h5555);
      step();

      // Oversized access types saturate to a full mask.
      request(1'b1, 64'h0000_0000_8000_4000, 1'b0, 64'h0, 4'd8);
      @(negedge clock);
      chk("type 8 mask", mem_mask, 64'hFF);
      step();
      serve(0, 1, 64'hA8);
      @(negedge clock);
      chk("type 8 rdata", lsu_rdata, 64'hA8);
      step();
      request(1'b1, 64'h0000_0000_8000_4008, 1'b0, 64'h0, 4'd15);
      @(negedge clock);
      chk("type 15 mask", mem_mask, 64'hFF);
      step();
      serve(0, 1, 64'hAF);
      @(negedge clock);
      chk("type 15 rdata", lsu_rdata, 64'hAF);
      step();

      // Reset while waiting for a response, then a stale response.
      request(1'b1, 64'h0000_0000_8000_5000, 1'b0, 64'h0, 4'd4);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("midreset mem_req_valid", mem_req_valid, 64'h0);
      chk("midreset ifu_rdata", ifu_rdata, 64'h0);
      chk("midreset lsu_rdata", lsu_rdata, 64'h0);
      chk("midreset mem_mask", mem_mask, 64'h0);
      step();
      reset = 1'b1;
      mem_resp_valid = 1'b1;
      mem_rdata = 64'h57A1E;
      step();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("stale lsu pulse", lsu_resp_valid, 64'h0);
      chk("stale lsu_rdata", lsu_rdata, 64'h0);
      step();
      request(1'b0, 64'h0000_0000_8000_6000, 1'b0, 64'h0, 4'd0);
      serve(0, 1, 64'h600D);
      @(negedge clock);
      chk("post-reset fetch pulse", ifu_resp_valid, 64'h1);
      chk("post-reset fetch data", ifu_rdata, 64'h600D);
      step();

      // Exactly one pulse per completed request, tallied by hand.
      chk("ifu pulse total", n_ifu_pulses, 64'd5);
      chk("lsu pulse total", n_lsu_pulses, 64'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
